sr_cmd_debounce: RTL and testbench

Upstream command stage for the clocked RS flip-flop. It takes two raw, asynchronous, bouncy request inputs (set and reset buttons or off-chip strobes), synchronises and debounces each one, and detects rising edges. It then drives single-cycle `S` / `R` pulses directly into the flip-flop's `S`/`R` inputs on the same `clk`. Simultaneous set and reset requests are suppressed and flagged, so the flip-flop never sees S=R=1 from this stage.

---
 rtl/sr_cmd_debounce.sv | 76 +++++++
 tb/tb_sr_cmd_debounce.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_debounce.sv
// Command front end for the clocked RS flip-flop: synchronises and debounces the
// raw set/reset requests, then emits one-cycle S/R pulses with conflict suppression.
module sr_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic rst_in,
  output logic S,
  output logic R,
  output logic conflict,
  output logic set_lvl,
  output logic rst_lvl
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         lvl_dly_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         rise;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               conf_q, conf_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == TC) lvl_d[i] = sync2_q[i];
        else                cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    rise   = lvl_q & ~lvl_dly_q;
    s_d    = rise[0] & ~rise[1];
    r_d    = rise[1] & ~rise[0];
    conf_d = rise[0] & rise[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      conf_q    <= 1'b0;
    end else begin
      sync1_q   <= {rst_in, set_in};
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      r_q       <= r_d;
      conf_q    <= conf_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign conflict = conf_q;
  assign set_lvl  = lvl_q[0];
  assign rst_lvl  = lvl_q[1];

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Bench for sr_cmd_debounce: vector tables, hand-written corner sequences and a
// randomized run against a sample-history reference model (N=4 and N=1 instances).
module tb_sr_cmd_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_in = 1'b0, rst_in = 1'b0;
  logic S, R, conflict, set_lvl, rst_lvl;
  logic set1_in = 1'b0, rst1_in = 1'b0;
  logic S1, R1, conflict1, set_lvl1, rst_lvl1;

  int checks = 0;
  int errors = 0;

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .set_in(set_in), .rst_in(rst_in),
    .S(S), .R(R), .conflict(conflict), .set_lvl(set_lvl), .rst_lvl(rst_lvl)
  );

  sr_cmd_debounce #(.DEBOUNCE_CYCLES(1)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .set_in(set1_in), .rst_in(rst1_in),
    .S(S1), .R(R1), .conflict(conflict1), .set_lvl(set_lvl1), .rst_lvl(rst_lvl1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit do_rst;
    bit set_v;
    bit rst_v;
    logic [4:0] exp;   // {S, R, conflict, set_lvl, rst_lvl}
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {S, R, conflict, set_lvl, rst_lvl};
  endfunction

  function automatic logic [4:0] outs1();
    return {S1, R1, conflict1, set_lvl1, rst_lvl1};
  endfunction

  // Called at a negedge; leaves rst_n released at a negedge with inputs low.
  task automatic do_reset();
    rst_n = 1'b0; set_in = 0; rst_in = 0; set1_in = 0; rst1_in = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: lvl flips once the last N synchronised samples all disagree with it.
  bit  m_pipe[2][$];
  bit  m_hist[2][$];
  bit  m_lvl[2];
  bit  m_lvl_old[2];
  logic [4:0] m_exp;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pipe[c] = {1'b0, 1'b0};
      m_hist[c].delete();
      m_lvl[c] = 0;
      m_lvl_old[c] = 0;
    end
    m_exp = '0;
  endfunction

  function automatic void model_step(input bit rs, input bit rr);
    bit rawv[2];
    bit rise[2];
    bit smp, all_diff;
    rawv[0] = rs; rawv[1] = rr;
    for (int c = 0; c < 2; c++) rise[c] = m_lvl[c] && !m_lvl_old[c];
    for (int c = 0; c < 2; c++) begin
      m_lvl_old[c] = m_lvl[c];
      smp = m_pipe[c].pop_front();
      m_pipe[c].push_back(rawv[c]);
      m_hist[c].push_back(smp);
      if (m_hist[c].size() > N) void'(m_hist[c].pop_front());
      all_diff = (m_hist[c].size() == N);
      foreach (m_hist[c][j]) if (m_hist[c][j] == m_lvl[c]) all_diff = 0;
      if (all_diff) begin
        m_lvl[c] = !m_lvl[c];
        m_hist[c].delete();
      end
    end
    m_exp = {rise[0] && !rise[1], rise[1] && !rise[0], rise[0] && rise[1], m_lvl[0], m_lvl[1]};
  endfunction

  function automatic void add_row(input bit r, input bit s, input bit q,
                                  input bit pS, input bit pR, input bit pC,
                                  input bit sl, input bit rl);
    vec_t v;
    v.do_rst = r; v.set_v = s; v.rst_v = q; v.exp = {pS, pR, pC, sl, rl};
    tbl.push_back(v);
  endfunction

  initial begin
    bit cs, cr;
    int x, pulses, rst_hold;

    // Clean set: 20 cycles held.
    for (int k = 0; k < 20; k++) add_row(k == 0, 1, 0, k == 6, 0, 0, k >= 5, 0);
    // Simultaneous rise.
    for (int k = 0; k < 10; k++) add_row(k == 0, 1, 1, 0, 0, k == 6, k >= 5, k >= 5);
    // Reset request one cycle behind set.
    for (int k = 0; k < 12; k++) add_row(k == 0, 1, k >= 1, k == 6, k == 7, 0, k >= 5, k >= 6);

    @(negedge clk);
    chk("reset_state", outs(), 5'b0);
    chk("reset_state_n1", outs1(), 5'b0);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      set_in = tbl[i].set_v; rst_in = tbl[i].rst_v;
      @(posedge clk); @(negedge clk);
      chk($sformatf("table_row%0d", i), outs(), tbl[i].exp);
      if (S && R) chk("s_r_exclusive", 5'b1, 5'b0);
    end

    // Bounce on set: never reaches the debounced level.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      set_in = (k == 0 || k == 2 || k == 3);
      @(posedge clk); @(negedge clk);
      chk("bounce_reject", outs(), 5'b0);
    end
    // A clean rise afterwards must show normal latency (count restarted).
    for (int k = 0; k < 10; k++) begin
      set_in = 1;
      @(posedge clk); @(negedge clk);
      chk("after_bounce", outs(), {k == 6, 1'b0, 1'b0, k >= 5, 1'b0});
    end

    // Reset asserted mid-count, input held across release.
    do_reset();
    set_in = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 5'b0);
    @(negedge clk);
    chk("held_in_reset", outs(), 5'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      chk("post_release", outs(), {k == 6, 1'b0, 1'b0, k >= 5, 1'b0});
    end

    // N=1: clean rise, a one-cycle drop while high re-triggers after lvl falls.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      rst1_in = (k != 6);
      @(posedge clk); @(negedge clk);
      chk("n1_rise_drop", outs1(),
          {1'b0, (k == 3 || k == 10), 1'b0, 1'b0, (k >= 2 && k != 8)});
    end
    // N=1: a single-cycle glitch registers as one pulse.
    do_reset();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      rst1_in = (k == 0);
      @(posedge clk); @(negedge clk);
      if (R1) pulses++;
      chk("n1_glitch_R", {4'b0, R1}, {4'b0, k == 3});
    end
    chk("n1_glitch_count", 5'(pulses), 5'd1);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    cs = 0; cr = 0; rst_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      x = $urandom_range(0, 99);
      if (x < 4) begin
        cs = !cs; cr = !cr;
      end else begin
        if (x < 10) cs = !cs;
        if ($urandom_range(0, 99) < 6) cr = !cr;
      end
      set_in = cs; rst_in = cr;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        rst_hold = $urandom_range(1, 3);
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(cs, cr);
      @(negedge clk);
      chk("random_vs_model", outs(), m_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
